// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data-memory responder for the 12-bit ARM CPU.
// One load or store is accepted per request. The access happens after a
// fixed number of wait states, then a one-cycle completion pulse is raised.
// Requests that arrive while an access is in flight are dropped, not queued.
module dmem_responder #(
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemoryRequest,
  input  logic              MemoryWrite,
  input  logic [ADDR_W-1:0] DataAdder,
  input  logic [DATA_W-1:0] WriteData,
  output logic              Busy,
  output logic [DATA_W-1:0] ReadData,
  output logic              ReadValid,
  output logic              WriteDone,
  output logic              AddrError
);

  // Word index width; the byte-offset bits [1:0] sit below the index.
  localparam int IW = $clog2(DEPTH);

  // Address bits above the word index; any of them set means out of range.
  // When ADDR_W == IW+2 the shift wraps to zero and the mask becomes empty.
  localparam logic [ADDR_W-1:0] HI_MASK =
    ~((ADDR_W'(1) << (IW + 2)) - ADDR_W'(1));

  // Wait-state reload value; the counter is always four bits wide.
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  // FSM encoding.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // Out-of-range test for a byte address. The whole address takes part in
  // the masked reduction, so the ignored byte-offset bits are still read.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
    return |(addr & HI_MASK);
  endfunction

  // Storage array: deliberately not reset, contents undefined until written.
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Control state.
  logic [0:0]        state_r;
  logic [3:0]        cnt_r;

  // Request copies captured at the accept edge; only these drive the access.
  logic              wr_r;
  logic [IW-1:0]     idx_r;
  logic              oor_r;
  logic [DATA_W-1:0] wdata_r;

  // Registered outputs.
  logic              busy_r;
  logic [DATA_W-1:0] rdata_r;
  logic              read_valid_r;
  logic              write_done_r;
  logic              addr_error_r;

  // Next-state decode.
  logic [0:0]        state_n_s;
  logic [3:0]        cnt_n_s;
  logic              accept_s;
  logic              access_s;
  logic              mem_we_s;

  // Next-state, counter and strobe decode for the two-state access FSM.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    accept_s  = 1'b0;
    access_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (MemoryRequest) begin
          accept_s  = 1'b1;
          state_n_s = ST_ACCESS;
          cnt_n_s   = WS_LOAD;
        end else begin
          state_n_s = ST_IDLE;
          cnt_n_s   = cnt_r;
        end
      end
      ST_ACCESS: begin
        if (cnt_r != 4'd0) begin
          state_n_s = ST_ACCESS;
          cnt_n_s   = cnt_r - 4'd1;
        end else begin
          access_s  = 1'b1;
          state_n_s = ST_IDLE;
          cnt_n_s   = 4'd0;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        cnt_n_s   = 4'd0;
      end
    endcase
  end

  // Array write enable: an in-range store reaching its access edge.
  always_comb begin
    mem_we_s = 1'b0;
    if (access_s && wr_r && !oor_r) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // FSM, request capture and registered outputs; reset aborts any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      wr_r         <= 1'b0;
      idx_r        <= '0;
      oor_r        <= 1'b0;
      wdata_r      <= '0;
      busy_r       <= 1'b0;
      rdata_r      <= '0;
      read_valid_r <= 1'b0;
      write_done_r <= 1'b0;
      addr_error_r <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      cnt_r        <= cnt_n_s;
      busy_r       <= (state_n_s == ST_ACCESS);
      read_valid_r <= access_s && !wr_r;
      write_done_r <= access_s && wr_r;
      addr_error_r <= access_s && oor_r;
      if (accept_s) begin
        wr_r    <= MemoryWrite;
        idx_r   <= DataAdder[IW+1:2];
        oor_r   <= addr_out_of_range(DataAdder);
        wdata_r <= WriteData;
      end
      if (access_s && !wr_r) begin
        rdata_r <= oor_r ? '0 : mem_r[idx_r];
      end
    end
  end

  // Array write port; reset high at the edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  assign Busy      = busy_r;
  assign ReadData  = rdata_r;
  assign ReadValid = read_valid_r;
  assign WriteDone = write_done_r;
  assign AddrError = addr_error_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a cycle-by-cycle vector table on a
// WAIT_STATES=2 instance, hand sequences for reset abort, and back-to-back
// traffic on a WAIT_STATES=0 instance.
module tb_dmem_responder;

  logic        clk;
  logic        reset;

  logic        req, wr;
  logic [11:0] addr, wdata;
  logic        busy, rv, wd, ae;
  logic [11:0] rdata;

  logic        req0, wr0;
  logic [11:0] addr0, wdata0;
  logic        busy0, rv0, wd0, ae0;
  logic [11:0] rdata0;

  int checks;
  int errors;

  dmem_responder #(.DATA_W(12), .ADDR_W(12), .DEPTH(64), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset),
    .MemoryRequest(req), .MemoryWrite(wr), .DataAdder(addr), .WriteData(wdata),
    .Busy(busy), .ReadData(rdata), .ReadValid(rv), .WriteDone(wd), .AddrError(ae)
  );

  dmem_responder #(.DATA_W(12), .ADDR_W(12), .DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .MemoryRequest(req0), .MemoryWrite(wr0), .DataAdder(addr0), .WriteData(wdata0),
    .Busy(busy0), .ReadData(rdata0), .ReadValid(rv0), .WriteDone(wd0), .AddrError(ae0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        wr;
    logic [11:0] addr;
    logic [11:0] wdata;
    logic        busy;
    logic        rv;
    logic        wd;
    logic        ae;
    logic [11:0] rdata;
  } vec_t;

  vec_t        vecs [0:63];
  int          nvec;
  logic [11:0] model_rd;

  task automatic check(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic w, input logic [11:0] a, input logic [11:0] d,
                         input logic b, input logic v, input logic wdn, input logic e, input logic [11:0] rd);
    vec_t x;
    x.req = r; x.wr = w; x.addr = a; x.wdata = d;
    x.busy = b; x.rv = v; x.wd = wdn; x.ae = e; x.rdata = rd;
    vecs[nvec] = x;
    nvec++;
  endtask

  // One transaction: accept edge, two wait edges, access edge with pulse.
  // With noise set, a competing store of 0x222 to 0x024 is held on the bus
  // during every busy cycle and must be ignored.
  task automatic add_txn(input logic w, input logic [11:0] a, input logic [11:0] d,
                         input logic [11:0] exp_rd, input logic e, input logic noise);
    add_vec(1'b1, w, a, d, 1'b1, 1'b0, 1'b0, 1'b0, model_rd);
    add_vec(noise, 1'b1, 12'h024, 12'h222, 1'b1, 1'b0, 1'b0, 1'b0, model_rd);
    add_vec(noise, 1'b1, 12'h024, 12'h222, 1'b1, 1'b0, 1'b0, 1'b0, model_rd);
    if (!w) model_rd = exp_rd;
    add_vec(noise, 1'b1, 12'h024, 12'h222, 1'b0, !w, w, e, model_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input int idx, input logic b, input logic v,
                           input logic wdn, input logic e, input logic [11:0] rd);
    check({name, ".busy"},  idx, {11'd0, busy}, {11'd0, b});
    check({name, ".rv"},    idx, {11'd0, rv},   {11'd0, v});
    check({name, ".wd"},    idx, {11'd0, wd},   {11'd0, wdn});
    check({name, ".ae"},    idx, {11'd0, ae},   {11'd0, e});
    check({name, ".rdata"}, idx, rdata, rd);
  endtask

  initial begin
    checks = 0; errors = 0; nvec = 0; model_rd = 12'h000;
    reset = 1'b1;
    req = 1'b0; wr = 1'b0; addr = 12'h000; wdata = 12'h000;
    req0 = 1'b0; wr0 = 1'b0; addr0 = 12'h000; wdata0 = 12'h000;

    // Vector table (WAIT_STATES=2, DEPTH=64).
    add_txn(1'b1, 12'h000, 12'h3C3, 12'h000, 1'b0, 1'b0); // seed word 0
    add_txn(1'b1, 12'h010, 12'hABC, 12'h000, 1'b0, 1'b0); // store ABC
    add_txn(1'b0, 12'h010, 12'h000, 12'hABC, 1'b0, 1'b0); // load back
    add_txn(1'b0, 12'h013, 12'h000, 12'hABC, 1'b0, 1'b0); // byte offset ignored
    add_txn(1'b1, 12'h100, 12'h555, 12'h000, 1'b1, 1'b0); // store out of range
    add_txn(1'b0, 12'h100, 12'h000, 12'h000, 1'b1, 1'b0); // load out of range
    add_txn(1'b0, 12'h000, 12'h000, 12'h3C3, 1'b0, 1'b0); // word 0 intact
    add_txn(1'b1, 12'h024, 12'h0AA, 12'h000, 1'b0, 1'b0); // prior value at 0x024
    add_txn(1'b1, 12'h020, 12'h111, 12'h000, 1'b0, 1'b1); // store with noise while busy
    add_txn(1'b0, 12'h024, 12'h000, 12'h0AA, 1'b0, 1'b0); // noise store dropped
    add_txn(1'b0, 12'h020, 12'h000, 12'h111, 1'b0, 1'b0); // real store landed
    add_txn(1'b1, 12'h030, 12'h0F0, 12'h000, 1'b0, 1'b0); // setup for reset abort

    // Reset state.
    tick();
    tick();
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check("reset.busy0", 0, {11'd0, busy0}, 12'h000);
    reset = 1'b0;

    // Apply table.
    for (int i = 0; i < nvec; i++) begin
      req = vecs[i].req; wr = vecs[i].wr; addr = vecs[i].addr; wdata = vecs[i].wdata;
      tick();
      check_all("vec", i, vecs[i].busy, vecs[i].rv, vecs[i].wd, vecs[i].ae, vecs[i].rdata);
    end

    // Reset during ACCESS aborts the store of 0x777 to 0x030.
    req = 1'b1; wr = 1'b1; addr = 12'h030; wdata = 12'h777;
    tick();
    check_all("abort.accept", 0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h111);
    req = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_all("abort.async", 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("abort.quiet", i, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    end
    req = 1'b1; wr = 1'b0; addr = 12'h030;
    tick();
    req = 1'b0;
    tick();
    tick();
    tick();
    check_all("abort.reload", 0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0F0);

    // WAIT_STATES=0: request held high, alternating store/load to 0x040.
    req0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr0    = (k % 2 == 0);
      addr0  = 12'h040;
      wdata0 = 12'h100 + 12'(k);
      tick();
      check("ws0.busy_hi", k, {11'd0, busy0}, 12'h001);
      check("ws0.idle_pulse", k, {10'd0, rv0, wd0}, 12'h000);
      tick();
      check("ws0.busy_lo", k, {11'd0, busy0}, 12'h000);
      check("ws0.pulse", k, {10'd0, rv0, wd0}, (k % 2 == 0) ? 12'h001 : 12'h002);
      check("ws0.ae", k, {11'd0, ae0}, 12'h000);
      if (k % 2 == 1) check("ws0.rdata", k, rdata0, 12'h100 + 12'(k - 1));
    end
    req0 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Wait-stated data-memory responder for the 12-bit ARM CPU. It sits on the processor's data-memory port, on the far side of MemoryWrite/DataAdder/WriteData/ReadData. It accepts one load or store per request, inserts a programmable number of wait states, then commits the store or returns the load word with a one-cycle completion pulse. It replaces the zero-latency data memory so the CPU's stall logic can be exercised against a slow responder.

## Interface

Parameters:
- DATA_W, 12, data word width
- ADDR_W, 12, DataAdder width
- DEPTH, 64, number of words in the array; power of two, 4..1024
- WAIT_STATES, 2, extra cycles between accept and access; 0..15

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately
- MemoryRequest  in  1  initiator has a valid access this cycle
- MemoryWrite  in  1  1 = store, 0 = load; sampled with MemoryRequest
- DataAdder  in  ADDR_W  byte address
- WriteData  in  DATA_W  store data
- Busy  out  1  access in progress; new requests are not accepted
- ReadData  out  DATA_W  last completed load value; held between loads
- ReadValid  out  1  one-cycle pulse: load completed, ReadData updated
- WriteDone  out  1  one-cycle pulse: store completed, or was discarded on error
- AddrError  out  1  one-cycle pulse, coincident with ReadValid/WriteDone, when the address is out of range

## Operation

- Word index is DataAdder[IW+1:2], where IW = log2(DEPTH). DataAdder[1:0] is ignored.
- An address is out of range if any DataAdder bit above IW+1 is 1.
- FSM has two states, IDLE and ACCESS. A counter is IW-independent, 4 bits wide.
- In IDLE, with Busy=0, MemoryRequest=1 at a rising edge:
  - latches MemoryWrite, DataAdder and WriteData;
  - loads the counter with WAIT_STATES;
  - moves to ACCESS.
- In ACCESS, with Busy=1:
  - if counter≠0, it decrements by 1 each edge;
  - if counter=0, the access is performed at that edge and the FSM returns to IDLE.
- Store, in range: array[index] ← latched WriteData. WriteDone=1.
- Store, out of range: array is unchanged. WriteDone=1, AddrError=1.
- Load, in range: ReadData ← array[index]. ReadValid=1.
- Load, out of range: ReadData ← 0. ReadValid=1, AddrError=1.
- MemoryRequest while Busy=1 is ignored and never queued. Inputs changing during ACCESS have no effect because the latched copies are used.
- The array is not reset; its contents are undefined until written.

## Timing

- Reset values: Busy=0, ReadData=0, ReadValid=0, WriteDone=0, AddrError=0. State=IDLE, counter=0.
- Accept edge is E0. Access edge is E0+WAIT_STATES+1.
  - Busy=1 from E0 until the access edge.
  - The pulses are high for exactly the cycle following the access edge; Busy=0 in that cycle.
- A request presented in the pulse cycle is accepted at the next edge.
- Maximum throughput: one access per WAIT_STATES+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted during ACCESS aborts the access: no array write, no pulse, ReadData=0.
- Reset asserted in a pulse cycle clears the pulse immediately.
- A WAIT_STATES value above 15 is a configuration error and is not supported.

## Test plan

1. WAIT_STATES=2: store 0xABC to DataAdder=0x010, accepted at E0. Required: Busy high for E0..E3, WriteDone pulse after E3. Then load 0x010: ReadValid pulse with ReadData=0xABC, AddrError=0.
2. Load DataAdder=0x013 after case 1. Required: ReadData=0xABC, since the low bits are ignored.
3. DEPTH=64: store 0x555 to 0x100. Required: WriteDone=1 and AddrError=1 in the same cycle. Load 0x100: ReadData=0x000, AddrError=1. Load 0x000 still returns its earlier contents.
4. Store to 0x020 with 0x111 is accepted. While Busy, pulse MemoryRequest with a store of 0x222 to 0x024. Required: only one WriteDone; 0x024 keeps its prior value.
5. Write 0x0F0 to 0x030. Then start a store of 0x777 to 0x030 and assert reset one edge after accept. Required: all outputs 0 immediately, no pulse; a later load of 0x030 returns 0x0F0.
6. WAIT_STATES=0: hold MemoryRequest high with alternating loads and stores. Required: one completion pulse every 2 cycles, and Busy toggling 1,0,1,0.
